// File: rtl/mtimer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp
// and a registered level-sensitive interrupt request.
module mtimer #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        hit,
   output logic        t_intr
);

   // Word index within the 32-byte window (addr[4:2]).
   localparam logic [2:0] W_MTIME_LO    = 3'd0;
   localparam logic [2:0] W_MTIME_HI    = 3'd1;
   localparam logic [2:0] W_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] W_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] W_CTRL        = 3'd4;
   localparam logic [2:0] W_STATUS      = 3'd5;

   logic [63:0] mtime_q,    mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        en_q,       en_d;
   logic [7:0]  presc_q,    presc_d;
   logic [7:0]  pcnt_q,     pcnt_d;
   logic        t_intr_q,   t_intr_d;

   logic [2:0]  widx;
   logic        aligned;
   logic        wr_ok;
   logic        we_mtime_lo;
   logic        we_mtime_hi;
   logic        we_cmp_lo;
   logic        we_cmp_hi;
   logic        we_ctrl;
   logic        tick;
   logic        cmp;

   assign hit     = (addr[31:5] == BASE_ADDR[31:5]);
   assign widx    = addr[4:2];
   assign aligned = (addr[1:0] == 2'b00);
   assign wr_ok   = wr_en && hit && aligned;

   assign we_mtime_lo = wr_ok && (widx == W_MTIME_LO);
   assign we_mtime_hi = wr_ok && (widx == W_MTIME_HI);
   assign we_cmp_lo   = wr_ok && (widx == W_MTIMECMP_LO);
   assign we_cmp_hi   = wr_ok && (widx == W_MTIMECMP_HI);
   assign we_ctrl     = wr_ok && (widx == W_CTRL);

   assign tick = en_q && (pcnt_q == presc_q);
   assign cmp  = (mtime_q >= mtimecmp_q);

   assign t_intr = t_intr_q;

   // Read mux reflects pre-write contents when a write hits in the same cycle.
   always_comb begin
      rdata = '0;
      if (rd_en && hit && aligned) begin
         case (widx)
            W_MTIME_LO:    rdata = mtime_q[31:0];
            W_MTIME_HI:    rdata = mtime_q[63:32];
            W_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
            W_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
            W_CTRL:        rdata = {16'h0000, presc_q, 7'b000_0000, en_q};
            W_STATUS:      rdata = {31'b0, t_intr_q};
            default:       rdata = '0;
         endcase
      end
   end

   always_comb begin
      // A software write to either half wins over the tick; halves never carry.
      mtime_d = mtime_q;
      if (tick && !(we_mtime_lo || we_mtime_hi)) begin
         mtime_d = mtime_q + 64'd1;
      end
      if (we_mtime_lo) begin
         mtime_d[31:0] = wdata;
      end
      if (we_mtime_hi) begin
         mtime_d[63:32] = wdata;
      end

      mtimecmp_d = mtimecmp_q;
      if (we_cmp_lo) begin
         mtimecmp_d[31:0] = wdata;
      end
      if (we_cmp_hi) begin
         mtimecmp_d[63:32] = wdata;
      end

      en_d    = en_q;
      presc_d = presc_q;
      if (we_ctrl) begin
         en_d    = wdata[0];
         presc_d = wdata[15:8];
      end

      if (!en_q || tick || we_ctrl) begin
         pcnt_d = '0;
      end else begin
         pcnt_d = pcnt_q + 8'd1;
      end

      t_intr_d = en_q && cmp;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         en_q       <= 1'b0;
         presc_q    <= '0;
         pcnt_q     <= '0;
         t_intr_q   <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         en_q       <= en_d;
         presc_q    <= presc_d;
         pcnt_q     <= pcnt_d;
         t_intr_q   <= t_intr_d;
      end
   end

endmodule
